onehot_decoder_seq: RTL and testbench

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with two modes.
- Decode mode: a valid/ready-qualified select code becomes a one-hot output one cycle later.
- Scan mode: the block walks the one-hot output through every index, dwelling a programmable number of cycles on each, with a wrap pulse.
- It drives chip-select, row-select and mux-enable fabrics in the combinational/sequential utility layer.

---
 rtl/onehot_decoder_seq_if.sv | 27 ++
 rtl/onehot_decoder_seq.sv | 117 +++++++++++
 tb/tb_onehot_decoder_seq.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_decoder_seq_if.sv
// Select/decode bundle for onehot_decoder_seq.
// Driver uses master, the decoder uses slave.
interface onehot_decoder_seq_if #(
    parameter int SEL_W = 2
);
    localparam int N = 1 << SEL_W;

    logic             i_en;
    logic             i_mode;
    logic             i_valid;
    logic [SEL_W-1:0] i_sel;
    logic             o_ready;
    logic [N-1:0]     o_y;
    logic             o_valid;
    logic [SEL_W-1:0] o_idx;
    logic             o_wrap;

    modport master (
        output i_en, i_mode, i_valid, i_sel,
        input  o_ready, o_y, o_valid, o_idx, o_wrap
    );

    modport slave (
        input  i_en, i_mode, i_valid, i_sel,
        output o_ready, o_y, o_valid, o_idx, o_wrap
    );
endinterface

// File: rtl/onehot_decoder_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with
// a handshaked decode mode and a dwell-timed scan mode.
module onehot_decoder_seq #(
    parameter int SEL_W      = 2,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    onehot_decoder_seq_if.slave  bus
);
    localparam int N  = 1 << SEL_W;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = {SEL_W{1'b1}};
    localparam logic [N-1:0]     Y_OFF =
        (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    typedef enum logic [1:0] {
        OFF,
        DEC,
        SCAN
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [N-1:0]     y_q;
    logic [SEL_W-1:0] idx_q;
    logic             ready_q;
    logic             valid_q;
    logic             wrap_q;
    logic             accept;
    logic [SEL_W-1:0] idx_nxt;

    // XOR with the inactive pattern yields one-cold when active-low
    function automatic logic [N-1:0] onehot(
        input logic [SEL_W-1:0] idx
    );
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v ^ Y_OFF;
    endfunction

    assign accept  = ready_q & bus.i_valid
                   & bus.i_en & ~bus.i_mode;
    assign idx_nxt = idx_q + SEL_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= OFF;
            cnt     <= '0;
            y_q     <= Y_OFF;
            idx_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            unique case (1'b1)
                !bus.i_en: begin
                    state   <= OFF;
                    cnt     <= '0;
                    y_q     <= Y_OFF;
                    idx_q   <= '0;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                    wrap_q  <= 1'b0;
                end
                bus.i_en && !bus.i_mode: begin
                    state   <= DEC;
                    cnt     <= '0;
                    ready_q <= 1'b1;
                    wrap_q  <= 1'b0;
                    if (state != DEC) begin
                        y_q     <= Y_OFF;
                        idx_q   <= '0;
                        valid_q <= 1'b0;
                    end else if (accept) begin
                        y_q     <= onehot(bus.i_sel);
                        idx_q   <= bus.i_sel;
                        valid_q <= 1'b1;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                bus.i_en && bus.i_mode: begin
                    state   <= SCAN;
                    ready_q <= 1'b0;
                    valid_q <= 1'b1;
                    if (state != SCAN) begin
                        cnt    <= '0;
                        idx_q  <= '0;
                        y_q    <= onehot('0);
                        wrap_q <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        idx_q  <= idx_nxt;
                        y_q    <= onehot(idx_nxt);
                        wrap_q <= (idx_q == IDX_LAST);
                    end else begin
                        cnt    <= cnt + CW'(1);
                        wrap_q <= 1'b0;
                    end
                end
                default: begin
                    state <= OFF;
                end
            endcase
        end
    end

    assign bus.o_y     = y_q;
    assign bus.o_idx   = idx_q;
    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_wrap  = wrap_q;
endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: two builds (DWELL=3 high,
// DWELL=1 low) share stimulus and are checked against a model.
module tb_onehot_decoder_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    onehot_decoder_seq_if #(.SEL_W(2)) ifa ();
    onehot_decoder_seq_if #(.SEL_W(2)) ifb ();

    onehot_decoder_seq #(
        .SEL_W(2), .DWELL(3), .ACTIVE_LOW(0)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .bus(ifa)
    );

    onehot_decoder_seq #(
        .SEL_W(2), .DWELL(1), .ACTIVE_LOW(1)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .bus(ifb)
    );

    typedef struct {
        int         st;
        logic [3:0] y;
        int         idx;
        bit         valid;
        bit         ready;
        bit         wrap;
        int         n;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;

    function automatic logic [3:0] oh(input int i, input bit al);
        logic [3:0] v;
        v = 4'b0001 << i;
        return al ? ~v : v;
    endfunction

    function automatic mdl_t mreset(input bit al);
        mdl_t r;
        r.st = 0; r.y = al ? 4'hf : 4'h0; r.idx = 0;
        r.valid = 0; r.ready = 0; r.wrap = 0; r.n = 0;
        return r;
    endfunction

    // st: 0 off, 1 decode, 2 scan; n = cycles since scan entry
    function automatic mdl_t mstep(input mdl_t m, input int dwell,
                                   input bit al, input bit en,
                                   input bit mode, input bit vld,
                                   input int sel);
        mdl_t r;
        r = m;
        r.wrap = 0;
        if (!en) begin
            r = mreset(al);
        end else if (!mode) begin
            r.ready = 1;
            if (m.st != 1) begin
                r.st = 1; r.y = al ? 4'hf : 4'h0;
                r.idx = 0; r.valid = 0;
            end else if (m.ready && vld) begin
                r.idx = sel; r.y = oh(sel, al); r.valid = 1;
            end else begin
                r.valid = 0;
            end
        end else begin
            r.ready = 0;
            r.valid = 1;
            r.n = (m.st == 2) ? m.n + 1 : 0;
            r.st = 2;
            r.idx = (r.n / dwell) % 4;
            r.wrap = (r.n > 0) && (r.n % (dwell * 4) == 0);
            r.y = oh(r.idx, al);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic mchk();
        chk("a_y", 32'(ifa.o_y), 32'(ma.y));
        chk("a_valid", 32'(ifa.o_valid), 32'(ma.valid));
        chk("a_ready", 32'(ifa.o_ready), 32'(ma.ready));
        chk("a_idx", 32'(ifa.o_idx), 32'(ma.idx));
        chk("a_wrap", 32'(ifa.o_wrap), 32'(ma.wrap));
        chk("b_y", 32'(ifb.o_y), 32'(mb.y));
        chk("b_valid", 32'(ifb.o_valid), 32'(mb.valid));
        chk("b_ready", 32'(ifb.o_ready), 32'(mb.ready));
        chk("b_idx", 32'(ifb.o_idx), 32'(mb.idx));
        chk("b_wrap", 32'(ifb.o_wrap), 32'(mb.wrap));
    endtask

    task automatic drv(input bit en, input bit mode,
                       input bit vld, input int sel);
        ifa.i_en = en; ifa.i_mode = mode;
        ifa.i_valid = vld; ifa.i_sel = 2'(sel);
        ifb.i_en = en; ifb.i_mode = mode;
        ifb.i_valid = vld; ifb.i_sel = 2'(sel);
    endtask

    task automatic step();
        @(posedge clk);
        ma = mstep(ma, 3, 0, ifa.i_en, ifa.i_mode,
                   ifa.i_valid, int'(ifa.i_sel));
        mb = mstep(mb, 1, 1, ifb.i_en, ifb.i_mode,
                   ifb.i_valid, int'(ifb.i_sel));
        #1;
        mchk();
    endtask

    initial begin
        int         exp_idx[13];
        logic [3:0] exp_b[5];
        bit         en;
        bit         mode;
        exp_idx = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        exp_b = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        drv(0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        ma = mreset(0);
        mb = mreset(1);
        mchk();
        #1 rst_n = 1'b1;

        // decode, back-to-back accepts
        drv(1, 0, 0, 0);
        step();
        chk("t1_ready", 32'(ifa.o_ready), 32'd1);
        drv(1, 0, 1, 2);
        step();
        chk("t1_y2", 32'(ifa.o_y), 32'h4);
        drv(1, 0, 1, 0);
        step();
        chk("t1_y0", 32'(ifa.o_y), 32'h1);
        drv(1, 0, 1, 3);
        step();
        chk("t1_y3", 32'(ifa.o_y), 32'h8);
        chk("t1_idx3", 32'(ifa.o_idx), 32'd3);
        drv(1, 0, 0, 1);
        step();
        chk("t1_hold_y", 32'(ifa.o_y), 32'h8);
        chk("t1_hold_v", 32'(ifa.o_valid), 32'd0);

        // scan with ignored valid pulses
        for (int i = 0; i < 13; i++) begin
            drv(1, 1, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
            step();
            chk("t2_idx", 32'(ifa.o_idx), 32'(exp_idx[i]));
            chk("t2_wrap", 32'(ifa.o_wrap), 32'(i == 12));
        end

        // advance to idx 2, counter 1, then leave scan
        repeat (7) step();
        chk("t3_pre_idx", 32'(ifa.o_idx), 32'd2);
        drv(1, 0, 1, 1);
        step();
        chk("t3_y_off", 32'(ifa.o_y), 32'h0);
        chk("t3_ready", 32'(ifa.o_ready), 32'd1);
        chk("t3_valid", 32'(ifa.o_valid), 32'd0);
        step();
        chk("t3_y1", 32'(ifa.o_y), 32'h2);

        // async reset mid-scan at idx 3
        drv(1, 1, 0, 0);
        repeat (10) step();
        chk("t4_pre_idx", 32'(ifa.o_idx), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        ma = mreset(0);
        mb = mreset(1);
        chk("t4_y", 32'(ifa.o_y), 32'h0);
        chk("t4_valid", 32'(ifa.o_valid), 32'd0);
        chk("t4_idx", 32'(ifa.o_idx), 32'd0);
        chk("t4_wrap", 32'(ifa.o_wrap), 32'd0);
        mchk();
        #2 rst_n = 1'b1;

        // active-low, DWELL=1 scan
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_y", 32'(ifb.o_y), 32'(exp_b[i]));
            chk("t5_wrap", 32'(ifb.o_wrap), 32'(i == 4));
        end

        // enable drop during an accept attempt
        drv(1, 0, 0, 0);
        step();
        step();
        drv(0, 0, 1, 3);
        step();
        chk("t6_y", 32'(ifa.o_y), 32'h0);
        chk("t6_ready", 32'(ifa.o_ready), 32'd0);
        chk("t6_yb", 32'(ifb.o_y), 32'hf);

        mode = 0;
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            drv(en, mode, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
